// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand fetch stage.
package operand_fetch_pkg;

  localparam int unsigned RegIdxW = 5;
  localparam logic [RegIdxW-1:0] RegZero = 5'd0;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StHold
  } of_state_e;

  // Writes to x0 are architecturally discarded, so they never forward.
  function automatic logic wb_hit(input logic en, input logic [RegIdxW-1:0] wb_adrs,
                                  input logic [RegIdxW-1:0] idx);
    return en && (wb_adrs != RegZero) && (wb_adrs == idx);
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode, register file, writeback and execute signals of the operand fetch stage.
interface operand_fetch_if
  import operand_fetch_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [RegIdxW-1:0] in_rs1;
  logic [RegIdxW-1:0] in_rs2;
  logic [TAG_W-1:0]   in_tag;
  logic [RegIdxW-1:0] rs1_adrs;
  logic [RegIdxW-1:0] rs2_adrs;
  logic [XLEN-1:0]    rs1_data;
  logic [XLEN-1:0]    rs2_data;
  logic               wb_en;
  logic [RegIdxW-1:0] wb_rd_adrs;
  logic [XLEN-1:0]    wb_rd_data;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_rs1_val;
  logic [XLEN-1:0]    out_rs2_val;
  logic [TAG_W-1:0]   out_tag;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_tag, rs1_data, rs2_data,
    input  wb_en, wb_rd_adrs, wb_rd_data, out_ready,
    output in_ready, rs1_adrs, rs2_adrs, out_valid, out_rs1_val, out_rs2_val, out_tag
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_tag, rs1_data, rs2_data,
    output wb_en, wb_rd_adrs, wb_rd_data, out_ready,
    input  in_ready, rs1_adrs, rs2_adrs, out_valid, out_rs1_val, out_rs2_val, out_tag
  );
endinterface

// File: rtl/operand_fetch_bypass.sv
// Per-operand forwarding: picks the newest value for one source register.
module operand_bypass
  import operand_fetch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [RegIdxW-1:0] idx_i,
  input  logic [XLEN-1:0]    held_i,
  input  logic [XLEN-1:0]    saved_i,
  input  logic               bypass_i,
  input  logic [XLEN-1:0]    rf_data_i,
  input  logic               capture_i,
  input  logic               wb_en_i,
  input  logic [RegIdxW-1:0] wb_adrs_i,
  input  logic [XLEN-1:0]    wb_data_i,
  output logic [XLEN-1:0]    out_val_o,
  output logic [XLEN-1:0]    held_d_o
);
  logic            hit;
  logic [XLEN-1:0] read_val;

  always_comb begin
    hit = wb_hit(wb_en_i, wb_adrs_i, idx_i);
    // Live writeback beats the saved accept-cycle write, which beats stale regfile data.
    if (idx_i == RegZero) begin
      read_val = '0;
    end else if (hit) begin
      read_val = wb_data_i;
    end else if (bypass_i) begin
      read_val = saved_i;
    end else begin
      read_val = rf_data_i;
    end
    out_val_o = hit ? wb_data_i : held_i;
    held_d_o  = capture_i ? read_val : out_val_o;
  end

endmodule

// File: rtl/operand_fetch.sv
// Issue-side operand fetch: regfile read latency absorption plus writeback forwarding.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input logic              clk_i,
  input logic              rst_i,
  operand_fetch_if.slave   bus_io
);
  of_state_e          state_q;
  logic               out_valid_q;
  logic [RegIdxW-1:0] idx1_q, idx2_q;
  logic [TAG_W-1:0]   tag_q;
  logic               byp1_q, byp2_q;
  logic [XLEN-1:0]    sav1_q, sav2_q;
  logic [XLEN-1:0]    held1_q, held2_q;
  logic [XLEN-1:0]    held1_d, held2_d;
  logic [XLEN-1:0]    val1, val2;
  logic               in_ready;
  logic               accept;
  logic               capture;

  assign in_ready = (state_q == StIdle) || ((state_q == StHold) && bus_io.out_ready);
  assign accept   = bus_io.in_valid && in_ready;
  assign capture  = (state_q == StRead);

  assign bus_io.in_ready    = in_ready;
  assign bus_io.rs1_adrs    = bus_io.in_rs1;
  assign bus_io.rs2_adrs    = bus_io.in_rs2;
  assign bus_io.out_valid   = out_valid_q;
  assign bus_io.out_rs1_val = val1;
  assign bus_io.out_rs2_val = val2;
  assign bus_io.out_tag     = tag_q;

  operand_bypass #(.XLEN(XLEN)) u_byp1 (
    .idx_i     (idx1_q),
    .held_i    (held1_q),
    .saved_i   (sav1_q),
    .bypass_i  (byp1_q),
    .rf_data_i (bus_io.rs1_data),
    .capture_i (capture),
    .wb_en_i   (bus_io.wb_en),
    .wb_adrs_i (bus_io.wb_rd_adrs),
    .wb_data_i (bus_io.wb_rd_data),
    .out_val_o (val1),
    .held_d_o  (held1_d)
  );

  operand_bypass #(.XLEN(XLEN)) u_byp2 (
    .idx_i     (idx2_q),
    .held_i    (held2_q),
    .saved_i   (sav2_q),
    .bypass_i  (byp2_q),
    .rf_data_i (bus_io.rs2_data),
    .capture_i (capture),
    .wb_en_i   (bus_io.wb_en),
    .wb_adrs_i (bus_io.wb_rd_adrs),
    .wb_data_i (bus_io.wb_rd_data),
    .out_val_o (val2),
    .held_d_o  (held2_d)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      idx1_q      <= RegZero;
      idx2_q      <= RegZero;
      tag_q       <= '0;
      byp1_q      <= 1'b0;
      byp2_q      <= 1'b0;
      sav1_q      <= '0;
      sav2_q      <= '0;
      held1_q     <= '0;
      held2_q     <= '0;
    end else begin
      held1_q <= held1_d;
      held2_q <= held2_d;
      // The regfile returns the pre-write value for an accept-cycle writeback, so keep it.
      if (accept) begin
        idx1_q <= bus_io.in_rs1;
        idx2_q <= bus_io.in_rs2;
        tag_q  <= bus_io.in_tag;
        byp1_q <= wb_hit(bus_io.wb_en, bus_io.wb_rd_adrs, bus_io.in_rs1);
        byp2_q <= wb_hit(bus_io.wb_en, bus_io.wb_rd_adrs, bus_io.in_rs2);
        sav1_q <= bus_io.wb_rd_data;
        sav2_q <= bus_io.wb_rd_data;
      end else if (capture) begin
        byp1_q <= 1'b0;
        byp2_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (accept) state_q <= StRead;
        end
        StRead: begin
          state_q     <= StHold;
          out_valid_q <= 1'b1;
        end
        StHold: begin
          if (bus_io.out_ready) begin
            state_q     <= accept ? StRead : StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed and random stimulus for operand_fetch against an architectural register model.
module tb_operand_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_fetch_if #(.XLEN(32), .TAG_W(8)) bus ();

  operand_fetch #(.XLEN(32), .TAG_W(8)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  // Register file with one-cycle registered read; doubles as the architectural state.
  logic [31:0] regs [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (bus.wb_en && bus.wb_rd_adrs != 5'd0) begin
      regs[bus.wb_rd_adrs] <= bus.wb_rd_data;
    end
    bus.rs1_data <= regs[bus.rs1_adrs];
    bus.rs2_data <= regs[bus.rs2_adrs];
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // At most one instruction is in flight; it becomes visible two cycles after acceptance.
  bit          have = 1'b0;
  logic [4:0]  q_rs1, q_rs2;
  logic [7:0]  q_tag;
  int          q_rdy;
  bit          exp_valid, exp_ready;

  function automatic logic [31:0] arch(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (bus.wb_en && bus.wb_rd_adrs == r) return bus.wb_rd_data;
    return regs[r];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [7:0] tg, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic ordy);
    bus.in_valid   = iv;
    bus.in_rs1     = r1;
    bus.in_rs2     = r2;
    bus.in_tag     = tg;
    bus.wb_en      = we;
    bus.wb_rd_adrs = wa;
    bus.wb_rd_data = wd;
    bus.out_ready  = ordy;
    #3;
    exp_valid = have && (cyc >= q_rdy);
    exp_ready = !have || (exp_valid && ordy);
    chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    chk("rs1_adrs", 32'(bus.rs1_adrs), 32'(r1));
    chk("rs2_adrs", 32'(bus.rs2_adrs), 32'(r2));
    if (exp_valid) begin
      chk("op1", bus.out_rs1_val, arch(q_rs1));
      chk("op2", bus.out_rs2_val, arch(q_rs2));
      chk("tag", 32'(bus.out_tag), 32'(q_tag));
    end
  endtask

  task automatic adv();
    if (exp_valid && bus.out_ready) have = 1'b0;
    if (bus.in_valid && exp_ready) begin
      have  = 1'b1;
      q_rs1 = bus.in_rs1;
      q_rs2 = bus.in_rs2;
      q_tag = bus.in_tag;
      q_rdy = cyc + 2;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    bus.in_valid = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_tag = 0;
    bus.wb_en = 0; bus.wb_rd_adrs = 0; bus.wb_rd_data = 0; bus.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_op1", bus.out_rs1_val, 32'd0);
    chk("rst_op2", bus.out_rs2_val, 32'd0);
    adv();

    // Plain read of a preloaded register
    drive(0, 0, 0, 0, 1, 5'd5, 32'h1234, 0); adv();
    drive(1, 5'd5, 5'd0, 8'h01, 0, 0, 0, 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("lat_n1", 32'(bus.out_valid), 32'd0);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("plain_op1", bus.out_rs1_val, 32'h1234);
    chk("plain_op2", bus.out_rs2_val, 32'h0);
    adv();

    // Writeback in accept cycle, regfile still returns the old value
    drive(1, 5'd7, 5'd7, 8'h02, 1, 5'd7, 32'hAAAA, 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("saved_op1", bus.out_rs1_val, 32'hAAAA);
    chk("saved_op2", bus.out_rs2_val, 32'hAAAA);
    adv();

    // Writeback in READ overrides the saved one
    drive(1, 5'd7, 5'd2, 8'h03, 1, 5'd7, 32'hA0A0, 0); adv();
    drive(0, 0, 0, 0, 1, 5'd7, 32'hBBBB, 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("newest_op1", bus.out_rs1_val, 32'hBBBB);
    adv();

    // Stall with a writeback to the held index
    drive(1, 5'd3, 5'd0, 8'h04, 0, 0, 0, 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0); adv();
    drive(0, 0, 0, 0, 1, 5'd3, 32'h55, 0);
    chk("stall_fwd", bus.out_rs1_val, 32'h55);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_held", bus.out_rs1_val, 32'h55);
    chk("stall_tag", 32'(bus.out_tag), 32'h04);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 1); adv();

    // x0 is never forwarded
    drive(1, 5'd0, 5'd0, 8'h05, 1, 5'd0, 32'hFFFF, 0); adv();
    drive(0, 0, 0, 0, 1, 5'd0, 32'hFFFF, 0); adv();
    drive(0, 0, 0, 0, 1, 5'd0, 32'hFFFF, 1);
    chk("x0_op1", bus.out_rs1_val, 32'h0);
    chk("x0_op2", bus.out_rs2_val, 32'h0);
    adv();

    // Back-to-back: transfer and accept in the same HOLD cycle
    drive(1, 5'd5, 5'd7, 8'h01, 0, 0, 0, 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0); adv();
    drive(1, 5'd3, 5'd5, 8'h02, 0, 0, 0, 1);
    chk("b2b_tag1", 32'(bus.out_tag), 32'h01);
    chk("b2b_ready", 32'(bus.in_ready), 32'd1);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("b2b_read", 32'(bus.out_valid), 32'd0);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("b2b_tag2", 32'(bus.out_tag), 32'h02);
    adv();

    // Reset while in READ discards the instruction
    drive(1, 5'd4, 5'd5, 8'h33, 0, 0, 0, 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("rst_read_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_read_ready", 32'(bus.in_ready), 32'd1);
    have = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    repeat (3) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      adv();
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            8'($urandom), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 9) < 7));
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
